simd_vec_unit: RTL

SIMD_VEC_UNIT -- requirements
Module: simd_vec_unit

---
 rtl/simd_vec_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/simd_vec_unit.sv
// simd_vec_unit: WIDTH-lane SIMD integer unit with per-lane accumulators.
// Two register stages. S1 captures the accepted operation. S2 computes the
// lane results, updates the accumulators and registers o_res/o_ovf.
//
// Handshake: an input transfer happens on a rising edge when
// i_valid && o_ready. An output transfer happens when o_valid && i_ready.
// o_ready = !(o_valid && !i_ready). It depends only on o_valid and i_ready.
// While the output is stalled, every register holds (S1, S2, accumulators).
module simd_vec_unit #(
    parameter int UNIT_SIZE = 32,
    parameter int WIDTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [2:0]                 i_op,
    input  logic [WIDTH-1:0]           i_mask,
    input  logic [WIDTH*UNIT_SIZE-1:0] i_a,
    input  logic [WIDTH*UNIT_SIZE-1:0] i_b,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH*UNIT_SIZE-1:0] o_res,
    output logic [WIDTH-1:0]           o_ovf
);

    localparam int VW = WIDTH * UNIT_SIZE;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_MAC    = 3'd3,
        OP_MACZ   = 3'd4,
        OP_ACCRD  = 3'd5,
        OP_ACCCLR = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    logic             stall;
    logic             advance;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_mask;
    logic [VW-1:0]    s1_a;
    logic [VW-1:0]    s1_b;

    logic [VW-1:0]    res_nxt;
    logic [WIDTH-1:0] ovf_nxt;

    assign stall   = o_valid && !i_ready;
    assign advance = !stall;
    assign o_ready = advance;

    // S1: capture the operation on an input transfer; insert a bubble otherwise
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_mask  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (advance) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_op   <= op_e'(i_op);
                s1_mask <= i_mask;
                s1_a    <= i_a;
                s1_b    <= i_b;
            end
        end
    end

    // S2: move the S1 valid into the output; results update only for real ops
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_res   <= '0;
            o_ovf   <= '0;
        end else if (advance) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_res <= res_nxt;
                o_ovf <= ovf_nxt;
            end
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        logic [UNIT_SIZE-1:0]   a_l;
        logic [UNIT_SIZE-1:0]   b_l;
        logic [UNIT_SIZE-1:0]   acc_q;
        logic [UNIT_SIZE-1:0]   acc_n;
        logic [UNIT_SIZE-1:0]   res_l;
        logic                   ovf_l;
        logic [2*UNIT_SIZE-1:0] prod;
        logic [UNIT_SIZE:0]     add_s;
        logic [UNIT_SIZE:0]     mac_s;
        logic                   prod_hi;

        assign a_l     = s1_a[k*UNIT_SIZE +: UNIT_SIZE];
        assign b_l     = s1_b[k*UNIT_SIZE +: UNIT_SIZE];
        assign prod    = {{UNIT_SIZE{1'b0}}, a_l} * {{UNIT_SIZE{1'b0}}, b_l};
        assign prod_hi = |prod[2*UNIT_SIZE-1:UNIT_SIZE];
        assign add_s   = {1'b0, a_l} + {1'b0, b_l};
        assign mac_s   = {1'b0, acc_q} + {1'b0, prod[UNIT_SIZE-1:0]};

        // Lane datapath: result, overflow and next accumulator for the S1 op.
        // A masked-off lane yields zero and leaves its accumulator as is.
        always_comb begin
            res_l = '0;
            ovf_l = 1'b0;
            acc_n = acc_q;
            if (s1_mask[k]) begin
                case (s1_op)
                    OP_ADD: begin
                        res_l = add_s[UNIT_SIZE-1:0];
                        ovf_l = add_s[UNIT_SIZE];
                    end
                    OP_SUB: begin
                        res_l = a_l - b_l;
                        ovf_l = (a_l < b_l);
                    end
                    OP_MUL: begin
                        res_l = prod[UNIT_SIZE-1:0];
                        ovf_l = prod_hi;
                    end
                    OP_MAC: begin
                        acc_n = mac_s[UNIT_SIZE-1:0];
                        res_l = mac_s[UNIT_SIZE-1:0];
                        ovf_l = prod_hi || mac_s[UNIT_SIZE];
                    end
                    OP_MACZ: begin
                        acc_n = prod[UNIT_SIZE-1:0];
                        res_l = prod[UNIT_SIZE-1:0];
                        ovf_l = prod_hi;
                    end
                    OP_ACCRD: begin
                        res_l = acc_q;
                    end
                    OP_ACCCLR: begin
                        acc_n = '0;
                    end
                    default: begin
                        res_l = '0;
                    end
                endcase
            end
        end

        // Accumulator is written only as a real op moves from S1 into S2, so
        // back-to-back MACs see the previous result without a bubble
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                acc_q <= '0;
            end else if (advance && s1_valid) begin
                acc_q <= acc_n;
            end
        end

        assign res_nxt[k*UNIT_SIZE +: UNIT_SIZE] = res_l;
        assign ovf_nxt[k]                        = ovf_l;
    end

endmodule
